// File: rtl/fpu_op_scheduler.sv
// -----------------------------------------------------------------------------
// fpu_op_scheduler
//
// Lets two requesters share one alu_fsm FPU core. The block grants one
// requester at a time, round-robin. It latches that requester's opcode and
// operands and holds them on the alu_* outputs. It then keeps the core in
// reset for KICK_CYCLES cycles with the operands stable, releases it, and
// waits for done. The result and flags are returned with the id of the
// requester that issued the command.
//
// Illegal opcodes (000, 110, 111) never reach the core. They are answered
// directly with result 0 and flags 3'b100.
//
// Optional feature (macro FPU_WATCHDOG_EN):
//   When the macro is defined, a watchdog aborts a run that has not seen
//   done within TIMEOUT_CYCLES cycles. The response then carries result 0,
//   flags 3'b100 and rsp_timeout=1.
//   When the macro is undefined, a run waits for done indefinitely and
//   rsp_timeout is tied to 0.
//
// Ports
//   clk, reset                    clock; asynchronous active-low reset
//   req{0,1}_valid/_ready         command handshake per requester
//   req{0,1}_opcode/_op_a/_op_b   command payload
//   rsp_valid/_ready              response handshake (held until accepted)
//   rsp_id/_result/_flags         response payload, flags = {exc, ovf, unf}
//   rsp_timeout                   run aborted by the watchdog
//   busy                          high whenever not idle
//   alu_reset/_opcode/_op_a/_op_b drive the shared core
//   alu_result/_exc/_ovf/_unf     results from the shared core
//   alu_done                      core completion pulse
// -----------------------------------------------------------------------------
module fpu_op_scheduler #(
    parameter int DATA_W         = 64,
    parameter int OP_W           = 3,
    parameter int KICK_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_opcode,
    input  logic [DATA_W-1:0] req0_op_a,
    input  logic [DATA_W-1:0] req0_op_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_opcode,
    input  logic [DATA_W-1:0] req1_op_a,
    input  logic [DATA_W-1:0] req1_op_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [2:0]        rsp_flags,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              alu_reset,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_op_a,
    output logic [DATA_W-1:0] alu_op_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_exc,
    input  logic              alu_ovf,
    input  logic              alu_unf,
    input  logic              alu_done
);

    localparam int KCW = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;

    if (KICK_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fpu_op_scheduler: KICK_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_KICK, S_RUN, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [KCW-1:0]    kick_q, kick_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [OP_W-1:0]   opc_q, opc_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [2:0]        flg_q, flg_d;
    logic              grant0, grant1;
    logic [OP_W-1:0]   sel_opc;

`ifdef FPU_WATCHDOG_EN
    // At least 11 bits so the default limit of 1024 fits with headroom.
    localparam int WDW = ($clog2(TIMEOUT_CYCLES + 1) > 11) ? $clog2(TIMEOUT_CYCLES + 1) : 11;
    logic [WDW-1:0] wd_q, wd_d;
    logic           to_q, to_d;
`endif

    function automatic logic legal_op(input logic [OP_W-1:0] op);
        return (op != '0) && (op <= OP_W'(5));
    endfunction

    always_comb begin
        state_d      = state_q;
        kick_d       = kick_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        opc_d        = opc_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        flg_d        = flg_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
        sel_opc      = req0_opcode;
`ifdef FPU_WATCHDOG_EN
        wd_d         = wd_q;
        to_d         = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                // On a tie, the requester that was not granted last goes first.
                grant0 = req0_valid && (!req1_valid || last_grant_q);
                grant1 = req1_valid && (!req0_valid || !last_grant_q);
                sel_opc = grant1 ? req1_opcode : req0_opcode;
                if (grant0 || grant1) begin
                    id_d         = grant1;
                    last_grant_d = grant1;
                    opc_d        = sel_opc;
                    a_d          = grant1 ? req1_op_a : req0_op_a;
                    b_d          = grant1 ? req1_op_b : req0_op_b;
`ifdef FPU_WATCHDOG_EN
                    to_d         = 1'b0;
`endif
                    if (legal_op(sel_opc)) begin
                        kick_d  = '0;
                        state_d = S_KICK;
                    end else begin
                        res_d   = '0;
                        flg_d   = 3'b100;
                        state_d = S_RESP;
                    end
                end
            end
            S_KICK: begin
                if (kick_q == KCW'(KICK_CYCLES - 1)) begin
                    state_d = S_RUN;
`ifdef FPU_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end else begin
                    kick_d = kick_q + 1'b1;
                end
            end
            S_RUN: begin
                // A done on the same cycle as the watchdog limit takes priority.
                if (alu_done) begin
                    res_d   = alu_result;
                    flg_d   = {alu_exc, alu_ovf, alu_unf};
                    state_d = S_RESP;
`ifdef FPU_WATCHDOG_EN
                end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    res_d   = '0;
                    flg_d   = 3'b100;
                    to_d    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            kick_q       <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            opc_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            flg_q        <= '0;
`ifdef FPU_WATCHDOG_EN
            wd_q         <= '0;
            to_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            kick_q       <= kick_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            opc_q        <= opc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            flg_q        <= flg_d;
`ifdef FPU_WATCHDOG_EN
            wd_q         <= wd_d;
            to_q         <= to_d;
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);
    // The core runs only in RUN and is held in reset in every other state.
    assign alu_reset  = (state_q != S_RUN);
    assign alu_opcode = opc_q;
    assign alu_op_a   = a_q;
    assign alu_op_b   = b_q;
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flg_q;
`ifdef FPU_WATCHDOG_EN
    assign rsp_timeout = to_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule
